div18_iter: RTL and testbench



---
 rtl/div18_pkg.sv | 19 +
 rtl/div18_iter_step.sv | 23 ++
 rtl/div18_iter.sv | 129 ++++++++++++
 tb/tb_div18_iter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/div18_pkg.sv
// Shared constants and state encoding for the iterative 18-bit divider.
package div18_pkg;

  localparam int WIDTH_DEF = 18;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  // Step counter must be able to hold WIDTH-1.
  function automatic int cnt_w(input int w);
    return $clog2(w) + 1;
  endfunction

  localparam int CNT_W_DEF = cnt_w(WIDTH_DEF);

endpackage

// File: rtl/div18_iter_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module div_step #(
  parameter int WIDTH = 18
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             dvd_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;
  logic             unused_hi;

  assign shifted = {rem_in, dvd_bit};
  assign trial   = {1'b0, shifted} - {2'b00, divisor};
  assign q_bit   = ~trial[WIDTH+1];
  // rem_in < divisor keeps the kept remainder inside WIDTH bits.
  assign rem_out = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign unused_hi = trial[WIDTH] ^ shifted[WIDTH];

endmodule

// File: rtl/div18_iter.sv
// Iterative divider: 1 accept + WIDTH restoring steps + 1 fix-up cycle, stallable by en.
// DIV18_SIGNED_EN selects two's-complement operands; undefined means unsigned.
module div18_iter
  import div18_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [1:0]       dbg_state
);

  localparam int CW = cnt_w(WIDTH);

  // Handshake: start is taken on an enabled edge with busy=0 (state IDLE);
  // start while busy is dropped. done pulses for one enabled cycle, and
  // Q/R/div0 hold their values until the next completion.

  state_t           st, st_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem, dvd, dvs, a_orig;
  logic             dz;
  logic [WIDTH-1:0] a_abs, b_abs, q_fix, r_fix;
  logic [WIDTH-1:0] step_rem;
  logic             step_q;

`ifdef DIV18_SIGNED_EN
  logic neg_q, neg_r;

  assign a_abs = A[WIDTH-1] ? -A : A;
  assign b_abs = B[WIDTH-1] ? -B : B;
  assign q_fix = neg_q ? -dvd : dvd;
  assign r_fix = neg_r ? -rem : rem;

  always_ff @(posedge clk) begin
    if (rst) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (en && st == IDLE && start) begin
      neg_q <= A[WIDTH-1] ^ B[WIDTH-1];
      neg_r <= A[WIDTH-1];
    end
  end
`else
  assign a_abs = A;
  assign b_abs = B;
  assign q_fix = dvd;
  assign r_fix = rem;
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem),
    .dvd_bit (dvd[WIDTH-1]),
    .divisor (dvs),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  always_ff @(posedge clk) begin
    if (rst) st <= IDLE;
    else if (en) st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    case (st)
      IDLE:    if (start) st_nxt = CALC;
      CALC:    if (cnt == CW'(WIDTH - 1)) st_nxt = FIX;
      FIX:     st_nxt = IDLE;
      default: st_nxt = IDLE;
    endcase
  end

  assign busy      = (st != IDLE);
  assign dbg_state = st;

  // dvd shifts the dividend out of its MSB while quotient bits enter its LSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      rem    <= '0;
      dvd    <= '0;
      dvs    <= '0;
      a_orig <= '0;
      dz     <= 1'b0;
      Q      <= '0;
      R      <= '0;
      div0   <= 1'b0;
      done   <= 1'b0;
    end else if (en) begin
      case (st)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            rem    <= '0;
            dvd    <= a_abs;
            dvs    <= b_abs;
            a_orig <= A;
            dz     <= (B == '0);
            cnt    <= '0;
          end
        end
        CALC: begin
          rem <= step_rem;
          dvd <= {dvd[WIDTH-2:0], step_q};
          cnt <= cnt + 1'b1;
        end
        FIX: begin
          // Divide by zero still runs full latency; result is forced here.
          Q    <= dz ? '1 : q_fix;
          R    <= dz ? a_orig : r_fix;
          div0 <= dz;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div18_iter.sv
// Directed bench for div18_iter: vector table plus stall, reset and back-to-back sequences.
module tb_div18_iter;
  import div18_pkg::*;

  localparam int W = WIDTH_DEF;

  logic         clk = 1'b0;
  logic         rst, en, start;
  logic [W-1:0] a, b, q, r;
  logic         busy, done, div0;
  logic [1:0]   dbg_state;

  // Clock / reset
  always #5 clk = ~clk;

  div18_iter #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .start     (start),
    .A         (a),
    .B         (b),
    .Q         (q),
    .R         (r),
    .busy      (busy),
    .done      (done),
    .div0      (div0),
    .dbg_state (dbg_state)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } vec_t;

  vec_t         tbl[$];
  logic [2*W:0] exp_q[$];
  int           n_vec = 0;
  int           n_bad = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic [W-1:0] ia, input logic [W-1:0] ib,
                     input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz);
    vec_t v;
    v.a = ia; v.b = ib; v.q = eq; v.r = er; v.dz = edz;
    tbl.push_back(v);
  endtask

  // Driver: one-cycle start pulse; returns at the sample point after the accept edge.
  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib);
    @(negedge clk);
    a = ia; b = ib; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits for done, counting sample points; optional en stall and stray start pulses.
  task automatic wait_done(input int stall_at, input int stall_len, input bit poke,
                           output int n, output int nbusy);
    n = 0;
    nbusy = 0;
    while (!done && n < 200) begin
      if (busy) nbusy++;
      if (n == stall_at) en = 1'b0;
      if (n == stall_at + stall_len) en = 1'b1;
      if (poke && n == 3) begin start = 1'b1; a = 18'd999; b = 18'd3; end
      if (poke && n == 6) start = 1'b0;
      @(negedge clk);
      n++;
    end
    en = 1'b1;
    start = 1'b0;
    if (!done) check("done_timeout", W'(done), W'(1));
  endtask

  // Scoreboard: compare the completed result against the oldest expectation.
  task automatic score(input string tag);
    logic [2*W:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, W'(exp_q.size()), W'(1));
    end else begin
      e = exp_q.pop_front();
      check({tag, "_q"}, q, e[W-1:0]);
      check({tag, "_r"}, r, e[2*W-1:W]);
      check({tag, "_div0"}, W'(div0), W'(e[2*W]));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    int n, nbusy;
    rst = 1'b1; en = 1'b1; start = 1'b0; a = '0; b = '0;

`ifdef DIV18_SIGNED_EN
    add(18'd100,     18'd7,       18'h3FFF2, 18'd2,     1'b0);
    add(18'h3FF9C,   18'd7,       18'h3FFF2, 18'h3FFFE, 1'b0);
    add(18'd100,     18'h3FFF9,   18'h3FFF2, 18'd2,     1'b0);
    add(18'h3FF9C,   18'h3FFF9,   18'd14,    18'h3FFFE, 1'b0);
    add(18'h20000,   18'h3FFFF,   18'h20000, 18'd0,     1'b0);
    add(18'd12345,   18'd0,       18'h3FFFF, 18'd12345, 1'b1);
    add(18'h3FFFB,   18'd0,       18'h3FFFF, 18'h3FFFB, 1'b1);
    add(18'h3FFFF,   18'd2,       18'd0,     18'h3FFFF, 1'b0);
    add(18'h1FFFF,   18'h20000,   18'd0,     18'h1FFFF, 1'b0);
    // First row fixed at 100/7 for the hand sequences; its Q is patched to 14.
    tbl[0].q = 18'd14;
`else
    add(18'd100,     18'd7,       18'd14,    18'd2,     1'b0);
    add(18'd12345,   18'd0,       18'h3FFFF, 18'd12345, 1'b1);
    add(18'h3FFFF,   18'd1,       18'h3FFFF, 18'd0,     1'b0);
    add(18'h3FFFF,   18'h3FFFF,   18'd1,     18'd0,     1'b0);
    add(18'd5,       18'd9,       18'd0,     18'd5,     1'b0);
    add(18'h20000,   18'd3,       18'd43690, 18'd2,     1'b0);
    add(18'h3FFFF,   18'd2,       18'h1FFFF, 18'd1,     1'b0);
    add(18'd0,       18'd5,       18'd0,     18'd0,     1'b0);
    add(18'd1000,    18'd1000,    18'd1,     18'd0,     1'b0);
    add(18'd0,       18'd0,       18'h3FFFF, 18'd0,     1'b1);
`endif

    repeat (3) @(negedge clk);
    check("rst_q",     q, 18'd0);
    check("rst_r",     r, 18'd0);
    check("rst_busy",  W'(busy), W'(0));
    check("rst_done",  W'(done), W'(0));
    check("rst_div0",  W'(div0), W'(0));
    check("rst_state", W'(dbg_state), W'(IDLE));
    rst = 1'b0;

    // Table vectors: result, latency 19, busy for 19 samples.
    foreach (tbl[i]) begin
      exp_q.push_back({tbl[i].dz, tbl[i].r, tbl[i].q});
      issue(tbl[i].a, tbl[i].b);
      wait_done(-1, 0, 1'b0, n, nbusy);
      check($sformatf("v%0d_latency", i), W'(n), W'(19));
      check($sformatf("v%0d_busy", i), W'(nbusy), W'(19));
      score($sformatf("v%0d", i));
    end

    // Stall 5 cycles mid-CALC with stray start pulses: latency 24, start ignored.
    exp_q.push_back({1'b0, 18'd2, 18'd14});
    issue(18'd100, 18'd7);
    wait_done(5, 5, 1'b1, n, nbusy);
    check("stall_latency", W'(n), W'(24));
    check("stall_busy", W'(nbusy), W'(24));
    score("stall");
    // done holds while en is low, then drops after one enabled cycle.
    en = 1'b0;
    repeat (3) @(negedge clk);
    check("done_hold", W'(done), W'(1));
    en = 1'b1;
    @(negedge clk);
    check("done_drop", W'(done), W'(0));
    check("no_queue_busy", W'(busy), W'(0));

    // Reset at cycle 10 of an operation aborts it and clears outputs.
    issue(18'd50000, 18'd3);
    repeat (9) @(negedge clk);
    check("pre_rst_busy", W'(busy), W'(1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", W'(busy), W'(0));
    check("abort_done", W'(done), W'(0));
    check("abort_q", q, 18'd0);
    check("abort_r", r, 18'd0);
    exp_q.push_back({1'b0, 18'd2, 18'd16666});
    issue(18'd50000, 18'd3);
    wait_done(-1, 0, 1'b0, n, nbusy);
    check("post_rst_latency", W'(n), W'(19));
    score("post_rst");

    // start held high: accepted again on each done cycle, one result per 20.
    @(negedge clk);
    a = 18'd1000; b = 18'd33; start = 1'b1;
    exp_q.push_back({1'b0, 18'd10, 18'd30});
    exp_q.push_back({1'b0, 18'd10, 18'd30});
    n = 0;
    @(negedge clk);
    n++;
    while (!done && n < 200) begin @(negedge clk); n++; end
    check("held_first_latency", W'(n), W'(20));
    score("held_first");
    n = 0;
    @(negedge clk);
    n++;
    check("held_reaccept_busy", W'(busy), W'(1));
    while (!done && n < 200) begin @(negedge clk); n++; end
    start = 1'b0;
    check("held_period", W'(n), W'(20));
    score("held_second");
    @(negedge clk);
    check("held_stop_busy", W'(busy), W'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
